// File: rtl/display_scanner_if.sv
// Bundle of the scanner's display-side signals; the scanner owns the o_* outputs,
// the surrounding controller owns the i_* inputs.
interface display_scanner_if;
  logic        i_tick;
  logic        i_enable;
  logic [15:0] i_digits;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic [3:0]  o_anode;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [1:0]  o_digit_sel;

  modport master (
    output i_tick, i_enable, i_digits, i_dp, i_blank_lz,
    input  o_anode, o_seg, o_dp, o_digit_sel
  );

  modport slave (
    input  i_tick, i_enable, i_digits, i_dp, i_blank_lz,
    output o_anode, o_seg, o_dp, o_digit_sel
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner: one digit per tick step, an all-dark
// guard before every digit change, per-frame input latching and leading-zero blanking.
module display_scanner #(
  parameter int GUARD_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  display_scanner_if.slave  bus
);

  localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  // Tick synchronizer and rising-edge detector
  logic tick_sync1, tick_sync2, tick_hist;
  logic step_p;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_sync1 <= 1'b0;
      tick_sync2 <= 1'b0;
      tick_hist  <= 1'b0;
    end else begin
      tick_sync1 <= bus.i_tick;
      tick_sync2 <= tick_sync1;
      tick_hist  <= tick_sync2;
    end
  end

  assign step_p = tick_sync2 & ~tick_hist;

  // Scan state
  logic [1:0]       state;
  logic [CNT_W-1:0] guard_cnt;
  logic [1:0]       idx;
  logic [15:0]      frame_digits;
  logic [3:0]       frame_dp;
  logic             frame_blz;
  logic [3:0]       anode;
  logic [6:0]       seg;
  logic             dp;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic digit_blanked(input logic [15:0] digits,
                                         input logic        blz,
                                         input logic [1:0]  sel);
    logic lz;
    case (sel)
      2'd3:    lz = (digits[15:12] == 4'h0);
      2'd2:    lz = (digits[15:8]  == 8'h00);
      2'd1:    lz = (digits[15:4]  == 12'h000);
      default: lz = 1'b0;
    endcase
    return blz & lz;
  endfunction

  // Next-slot decode; a step into digit 0 opens a new frame and uses live inputs.
  logic [1:0]  next_idx;
  logic [15:0] src_digits;
  logic [3:0]  src_dp;
  logic        src_blz;
  logic        next_blank;
  logic [6:0]  next_seg;
  logic        next_dp;
  logic [3:0]  on_anode;

  // NOTE: each always_comb output gets a default at the top so no path leaves it
  // unassigned, which is what keeps latches from being inferred.
  always_comb begin
    next_idx   = idx + 2'd1;
    src_digits = frame_digits;
    src_dp     = frame_dp;
    src_blz    = frame_blz;
    if (next_idx == 2'd0) begin
      src_digits = bus.i_digits;
      src_dp     = bus.i_dp;
      src_blz    = bus.i_blank_lz;
    end
    next_blank = digit_blanked(src_digits, src_blz, next_idx);
    next_seg   = next_blank ? 7'h7F : hex_to_seg(src_digits[{next_idx, 2'b00} +: 4]);
    next_dp    = next_blank | ~src_dp[next_idx];
    on_anode   = digit_blanked(frame_digits, frame_blz, idx) ? 4'hF
                                                             : ~(4'b0001 << idx);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      guard_cnt    <= '0;
      idx          <= 2'd3;
      // NOTE: the frame latch is a handful of flops, not a RAM, so it is reset to
      // keep the first blanking decision after reset free of X.
      frame_digits <= 16'h0000;
      frame_dp     <= 4'h0;
      frame_blz    <= 1'b0;
      anode        <= 4'hF;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else if (!bus.i_enable) begin
      state <= ST_IDLE;
      anode <= 4'hF;
    end else if (step_p) begin
      // Segments change with the anodes dark so they settle during the guard.
      state     <= ST_GUARD;
      guard_cnt <= '0;
      idx       <= next_idx;
      anode     <= 4'hF;
      seg       <= next_seg;
      dp        <= next_dp;
      if (next_idx == 2'd0) begin
        frame_digits <= bus.i_digits;
        frame_dp     <= bus.i_dp;
        frame_blz    <= bus.i_blank_lz;
      end
    end else begin
      case (state)
        ST_GUARD: begin
          if (guard_cnt == CNT_LAST) begin
            state <= ST_ON;
            anode <= on_anode;
          end else begin
            guard_cnt <= guard_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_anode     = anode;
  assign bus.o_seg       = seg;
  assign bus.o_dp        = dp;
  assign bus.o_digit_sel = idx;

endmodule
